// File: rtl/pwm_cap_pkg.sv
// Shared state encoding, counter width and saturating-increment helper for PWM capture.
// No logic of its own: types, constants and one pure function.
package pwm_cap_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RISE,
    ST_MEAS_HIGH,
    ST_MEAS_LOW,
    ST_TIMEOUT
  } cap_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/pwm_in_filter.sv
// Synchronizes PWM_IN, deglitches it (FILTER_LEN-cycle hold) and emits one-cycle rise/fall pulses.
// Latency: pulses SYNC_STAGES+FILTER_LEN cycles after the first sampling edge; no backpressure.
module pwm_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic PWM_IN,
  output logic filt_lvl,
  output logic rise_pls,
  output logic fall_pls
);

  localparam logic [3:0] HOLD_LAST = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             hold_cnt;
  logic                   filt_q;
  logic                   filt_d1;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign filt_lvl = filt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q   <= '0;
      hold_cnt <= '0;
      filt_q   <= 1'b0;
      filt_d1  <= 1'b0;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
      // Any cycle agreeing with the current level restarts the hold count.
      if (sync_lvl != filt_q) begin
        if (hold_cnt == HOLD_LAST) begin
          filt_q   <= sync_lvl;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 4'd1;
        end
      end else begin
        hold_cnt <= '0;
      end
      filt_d1  <= filt_q;
      rise_pls <= filt_q & ~filt_d1;
      fall_pls <= ~filt_q & filt_d1;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a filtered PWM input, with stuck-signal timeout detection.
// Latency: MEAS_Valid one cycle after the closing accepted rise; no backpressure (outputs are sampled).
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             PWM_IN,
  input  logic [CNT_W-1:0] TIMEOUT_Cnt_Set,
  output logic [CNT_W-1:0] PERIOD_Cnt,
  output logic [CNT_W-1:0] HIGH_Cnt,
  output logic             MEAS_Valid,
  output logic             TIMEOUT_Flag,
  output logic             STUCK_Level
);

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_d, hcnt_d;
  logic             valid_d, flag_d, stuck_d;
  logic             filt_lvl, rise_pls, fall_pls;
  logic             tmo_hit, go_tmo;

  pwm_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .CLK     (CLK),
    .RST     (RST),
    .PWM_IN  (PWM_IN),
    .filt_lvl(filt_lvl),
    .rise_pls(rise_pls),
    .fall_pls(fall_pls)
  );

  assign tmo_hit = (TIMEOUT_Cnt_Set != '0) && (cnt_q >= TIMEOUT_Cnt_Set);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A rise always beats a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:      state_d = ST_WAIT_RISE;
        ST_WAIT_RISE: if (rise_pls) state_d = ST_MEAS_HIGH;
                      else if (tmo_hit) state_d = ST_TIMEOUT;
        ST_MEAS_HIGH: if (tmo_hit) state_d = ST_TIMEOUT;
                      else if (fall_pls) state_d = ST_MEAS_LOW;
        ST_MEAS_LOW:  if (rise_pls) state_d = ST_MEAS_HIGH;
                      else if (tmo_hit) state_d = ST_TIMEOUT;
        ST_TIMEOUT:   if (rise_pls) state_d = ST_MEAS_HIGH;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = sat_inc(cnt_q);
    high_d   = high_q;
    period_d = PERIOD_Cnt;
    hcnt_d   = HIGH_Cnt;
    valid_d  = 1'b0;
    flag_d   = TIMEOUT_Flag;
    stuck_d  = STUCK_Level;
    go_tmo   = 1'b0;
    if (!EN) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: cnt_d = '0;
        ST_WAIT_RISE: begin
          if (rise_pls)     cnt_d = CNT_ONE;
          else if (tmo_hit) go_tmo = 1'b1;
        end
        ST_MEAS_HIGH: begin
          if (tmo_hit)       go_tmo = 1'b1;
          else if (fall_pls) high_d = cnt_q;
        end
        ST_MEAS_LOW: begin
          if (rise_pls) begin
            cnt_d    = CNT_ONE;
            period_d = cnt_q;
            hcnt_d   = high_q;
            valid_d  = 1'b1;
          end else if (tmo_hit) begin
            go_tmo = 1'b1;
          end
        end
        ST_TIMEOUT: begin
          if (rise_pls) begin
            cnt_d  = CNT_ONE;
            flag_d = 1'b0;
          end
        end
        default: cnt_d = '0;
      endcase
      if (go_tmo) begin
        flag_d   = 1'b1;
        stuck_d  = filt_lvl;
        period_d = '0;
        hcnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      high_q       <= '0;
      PERIOD_Cnt   <= '0;
      HIGH_Cnt     <= '0;
      MEAS_Valid   <= 1'b0;
      TIMEOUT_Flag <= 1'b0;
      STUCK_Level  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      high_q       <= high_d;
      PERIOD_Cnt   <= period_d;
      HIGH_Cnt     <= hcnt_d;
      MEAS_Valid   <= valid_d;
      TIMEOUT_Flag <= flag_d;
      STUCK_Level  <= stuck_d;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: edges derived from the sampled input with a run-length rule, measurements
// queued as (period, high, cycle) and popped by a monitor whenever MEAS_Valid shows up.
module tb_pwm_capture;

  localparam int S  = 2;
  localparam int FL = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        PWM_IN = 1'b0;
  logic [31:0] TIMEOUT_Cnt_Set = 32'd500;
  logic [31:0] PERIOD_Cnt, HIGH_Cnt;
  logic        MEAS_Valid, TIMEOUT_Flag, STUCK_Level;

  pwm_capture #(.SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .EN             (EN),
    .PWM_IN         (PWM_IN),
    .TIMEOUT_Cnt_Set(TIMEOUT_Cnt_Set),
    .PERIOD_Cnt     (PERIOD_Cnt),
    .HIGH_Cnt       (HIGH_Cnt),
    .MEAS_Valid     (MEAS_Valid),
    .TIMEOUT_Flag   (TIMEOUT_Flag),
    .STUCK_Level    (STUCK_Level)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned period;
    int unsigned high;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: accepted level, run length, enable, last rise/fall sample indices.
  logic        m_lvl = 1'b0;
  int          m_run = 0;
  bit          m_en = 1'b0;
  bit          m_have_rise = 1'b0;
  bit          m_have_fall = 1'b0;
  int          m_rise_k = 0;
  int          m_fall_k = 0;
  int unsigned last_period = 0;
  int unsigned last_high = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic accept_edge(input logic v, input int ke);
    exp_t e;
    if (!m_en) return;
    if (v) begin
      if (m_have_rise && m_have_fall) begin
        e.period = ke - m_rise_k;
        e.high   = m_fall_k - m_rise_k;
        e.cyc    = ke + S + FL + 1;
        sbq.push_back(e);
        last_period = e.period;
        last_high   = e.high;
      end
      m_rise_k    = ke;
      m_have_rise = 1'b1;
      m_have_fall = 1'b0;
    end else if (m_have_rise) begin
      m_fall_k    = ke;
      m_have_fall = 1'b1;
    end
  endtask

  // A new level counts once FL consecutive samples show it; its edge dates from the first of them.
  task automatic model_sample(input logic v, input int k);
    if (v != m_lvl) begin
      m_run++;
      if (m_run == FL) begin
        m_lvl = v;
        m_run = 0;
        accept_edge(v, k - FL + 1);
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic m_drop(input bit clear_outputs);
    m_have_rise = 1'b0;
    m_have_fall = 1'b0;
    if (clear_outputs) begin
      last_period = 0;
      last_high   = 0;
    end
  endtask

  task automatic run_level(input logic v, input int n);
    repeat (n) begin
      @(negedge CLK);
      PWM_IN = v;
      model_sample(v, cyc + 1);
    end
  endtask

  task automatic pwm_period(input int per, input int hi);
    run_level(1'b1, hi);
    run_level(1'b0, per - hi);
  endtask

  task automatic pwm_glitchy(input int per, input int hi);
    run_level(1'b1, hi);
    run_level(1'b0, 30);
    run_level(1'b1, 3);
    run_level(1'b0, 20);
    run_level(1'b1, 3);
    run_level(1'b0, per - hi - 56);
  endtask

  // Monitor: retire expired entries as misses, then compare each valid against the queue head.
  always @(negedge CLK) begin
    exp_t e;
    while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_valid cyc=%0d expected at cyc=%0d period=%0d high=%0d",
               cyc, e.cyc, e.period, e.high);
    end
    if (MEAS_Valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid cyc=%0d period=%0d high=%0d expected no valid",
                 cyc, PERIOD_Cnt, HIGH_Cnt);
      end else begin
        e = sbq.pop_front();
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
        check("period", 64'(PERIOD_Cnt), 64'(e.period));
        check("high", 64'(HIGH_Cnt), 64'(e.high));
      end
    end
  end

  initial begin
    int per, hi, lo, a, g;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_period", 64'(PERIOD_Cnt), 64'd0);
    check("rst_high", 64'(HIGH_Cnt), 64'd0);
    check("rst_valid", 64'(MEAS_Valid), 64'd0);
    check("rst_flag", 64'(TIMEOUT_Flag), 64'd0);
    check("rst_stuck", 64'(STUCK_Level), 64'd0);
    EN   = 1'b1;
    m_en = 1'b1;
    run_level(1'b0, 10);

    // Nominal 100/25, glitches in the low phase, then a duty step to 75.
    repeat (4) pwm_period(100, 25);
    repeat (4) pwm_glitchy(100, 25);
    repeat (4) pwm_period(100, 75);

    // Stuck low past the 500-cycle limit.
    run_level(1'b0, 700);
    check("tmo_low_flag", 64'(TIMEOUT_Flag), 64'd1);
    check("tmo_low_stuck", 64'(STUCK_Level), 64'd0);
    check("tmo_low_period", 64'(PERIOD_Cnt), 64'd0);
    check("tmo_low_high", 64'(HIGH_Cnt), 64'd0);
    m_drop(1'b1);
    run_level(1'b1, 25);
    check("tmo_exit_flag", 64'(TIMEOUT_Flag), 64'd0);
    run_level(1'b0, 75);
    repeat (3) pwm_period(100, 25);

    // Stuck high, then the same long high with the timeout disabled.
    run_level(1'b1, 700);
    check("tmo_high_flag", 64'(TIMEOUT_Flag), 64'd1);
    check("tmo_high_stuck", 64'(STUCK_Level), 64'd1);
    check("tmo_high_period", 64'(PERIOD_Cnt), 64'd0);
    m_drop(1'b1);
    @(negedge CLK);
    TIMEOUT_Cnt_Set = 32'd0;
    PWM_IN = 1'b1;
    model_sample(1'b1, cyc + 1);
    run_level(1'b0, 50);
    run_level(1'b1, 1500);
    check("no_tmo_flag", 64'(TIMEOUT_Flag), 64'd0);
    run_level(1'b0, 200);
    pwm_period(100, 30);

    // Randomized periods, duties and short glitches.
    for (int i = 0; i < 30; i++) begin
      per = int'($urandom_range(20, 200));
      hi  = int'($urandom_range(FL + 1, per - FL - 1));
      lo  = per - hi;
      run_level(1'b1, hi);
      if (lo > 14 && $urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(4, lo - 10));
        g = int'($urandom_range(1, FL - 1));
        run_level(1'b0, a);
        run_level(1'b1, g);
        run_level(1'b0, lo - a - g);
      end else begin
        run_level(1'b0, lo);
      end
    end
    TIMEOUT_Cnt_Set = 32'd500;
    repeat (3) pwm_period(100, 25);

    // Reset at cycle 40 of a period.
    run_level(1'b1, 25);
    run_level(1'b0, 15);
    @(negedge CLK);
    RST = 1'b1;
    PWM_IN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_period", 64'(PERIOD_Cnt), 64'd0);
    check("midrst_high", 64'(HIGH_Cnt), 64'd0);
    check("midrst_valid", 64'(MEAS_Valid), 64'd0);
    check("midrst_flag", 64'(TIMEOUT_Flag), 64'd0);
    check("midrst_stuck", 64'(STUCK_Level), 64'd0);
    m_lvl = 1'b0;
    m_run = 0;
    m_drop(1'b1);
    model_sample(1'b0, cyc + 1);
    run_level(1'b0, 58);
    repeat (3) pwm_period(100, 25);

    // Enable dropped mid-measurement while the input keeps toggling.
    run_level(1'b1, 25);
    run_level(1'b0, 35);
    @(negedge CLK);
    EN = 1'b0;
    m_en = 1'b0;
    m_drop(1'b0);
    model_sample(1'b0, cyc + 1);
    run_level(1'b0, 39);
    repeat (3) pwm_period(100, 60);
    check("en_off_period", 64'(PERIOD_Cnt), 64'(last_period));
    check("en_off_high", 64'(HIGH_Cnt), 64'(last_high));
    check("en_off_flag", 64'(TIMEOUT_Flag), 64'd0);
    run_level(1'b1, 25);
    run_level(1'b0, 35);
    @(negedge CLK);
    EN = 1'b1;
    m_en = 1'b1;
    model_sample(1'b0, cyc + 1);
    run_level(1'b0, 39);
    repeat (3) pwm_period(100, 40);
    run_level(1'b1, 20);
    run_level(1'b0, 20);

    check("sb_drain", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
